// File: rtl/mdio_receptor.sv
// PHY-side MDIO frame receiver with a 32x16 register bank; mdc is sampled in the clk domain.
// Define MDIO_PHYADDR_CHECK_EN to silently drop frames whose PHYAD differs from PHY_ADDR.
module mdio_receptor #(
  parameter logic [4:0] PHY_ADDR = 5'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdc,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  output logic        mdio_in,
  output logic        mdio_in_oe,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_done,
  output logic        frame_err
);

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 16;
  localparam int unsigned CW   = 5;
  localparam int unsigned NREG = 32;

  typedef enum logic [3:0] {
    S_IDLE, S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA_W, S_WDATA, S_TA_R, S_RDATA, S_SKIP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [DW-1:0]   rd_sh_q, rd_sh_d;
  logic [AW-1:0]   regad_q, regad_d;
  logic            is_rd_q, is_rd_d;
  logic            mdc_q;
  logic            mdio_in_q, mdio_in_d;
  logic            mdio_in_oe_q, mdio_in_oe_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            rd_done_q, rd_done_d;
  logic            frame_err_q, frame_err_d;
  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic            rise_c, fall_c;
  logic [DW-1:0]   samp_c;

`ifdef MDIO_PHYADDR_CHECK_EN
  logic [AW-1:0]   phyad_q, phyad_d;
`else
  logic            unused_phy_addr_c;
  assign unused_phy_addr_c = ^PHY_ADDR;
`endif

  assign rise_c = mdc & ~mdc_q;
  assign fall_c = ~mdc & mdc_q;
  assign samp_c = {shreg_q[DW-2:0], mdio_out};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      rd_sh_q      <= '0;
      regad_q      <= '0;
      is_rd_q      <= 1'b0;
      mdc_q        <= 1'b0;
      mdio_in_q    <= 1'b0;
      mdio_in_oe_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      regs_q       <= '{default: '0};
`ifdef MDIO_PHYADDR_CHECK_EN
      phyad_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      rd_sh_q      <= rd_sh_d;
      regad_q      <= regad_d;
      is_rd_q      <= is_rd_d;
      mdc_q        <= mdc;
      mdio_in_q    <= mdio_in_d;
      mdio_in_oe_q <= mdio_in_oe_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_done_q    <= rd_done_d;
      frame_err_q  <= frame_err_d;
      regs_q       <= regs_d;
`ifdef MDIO_PHYADDR_CHECK_EN
      phyad_q      <= phyad_d;
`endif
    end
  end

  // Frame decode: every field advances on an mdc rise; read data is launched on falls.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    rd_sh_d      = rd_sh_q;
    regad_d      = regad_q;
    is_rd_d      = is_rd_q;
    mdio_in_d    = mdio_in_q;
    mdio_in_oe_d = mdio_in_oe_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    rd_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    regs_d       = regs_q;
`ifdef MDIO_PHYADDR_CHECK_EN
    phyad_d      = phyad_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rise_c && mdio_oe && !mdio_out) state_d = S_ST1;
      end

      S_ST1, S_OP, S_PHYAD, S_REGAD, S_TA_W, S_WDATA: begin
        if (rise_c) begin
          if (!mdio_oe) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
            shreg_d   = samp_c;
            case (state_q)
              S_ST1: begin
                if (mdio_out) begin
                  state_d = S_OP;
                end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
                end
              end
              S_OP: begin
                if (bit_cnt_q == CW'(1)) begin
                  if (samp_c[1:0] == 2'b01) begin
                    is_rd_d = 1'b0;
                    state_d = S_PHYAD;
                  end else if (samp_c[1:0] == 2'b10) begin
                    is_rd_d = 1'b1;
                    state_d = S_PHYAD;
                  end else begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                  end
                end
              end
              S_PHYAD: begin
                if (bit_cnt_q == CW'(4)) begin
`ifdef MDIO_PHYADDR_CHECK_EN
                  phyad_d = samp_c[AW-1:0];
`endif
                  state_d = S_REGAD;
                end
              end
              S_REGAD: begin
                if (bit_cnt_q == CW'(4)) begin
                  regad_d = samp_c[AW-1:0];
`ifdef MDIO_PHYADDR_CHECK_EN
                  if (phyad_q != PHY_ADDR) state_d = S_SKIP;
                  else
`endif
                  if (is_rd_q) begin
                    rd_sh_d = regs_q[samp_c[AW-1:0]];
                    state_d = S_TA_R;
                  end else begin
                    state_d = S_TA_W;
                  end
                end
              end
              S_TA_W: begin
                if (bit_cnt_q == CW'(0)) begin
                  if (!mdio_out) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                  end
                end else if (mdio_out) begin
                  frame_err_d = 1'b1;
                  state_d     = S_IDLE;
                end else begin
                  state_d = S_WDATA;
                end
              end
              S_WDATA: begin
                if (bit_cnt_q == CW'(15)) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = regad_q;
                  wr_data_d = samp_c;
                  // Register 0 is hard-wired to zero; the write is still acknowledged.
                  if (regad_q != '0) regs_d[regad_q] = samp_c;
                  state_d = S_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      end

      S_TA_R: begin
        if (rise_c) begin
          if (mdio_oe) begin
            frame_err_d  = 1'b1;
            mdio_in_oe_d = 1'b0;
            mdio_in_d    = 1'b0;
            state_d      = S_IDLE;
          end else begin
            state_d = S_RDATA;
          end
        end else if (fall_c) begin
          mdio_in_oe_d = 1'b1;
          mdio_in_d    = 1'b0;
        end
      end

      S_RDATA: begin
        if (rise_c) begin
          if (mdio_oe) begin
            frame_err_d  = 1'b1;
            mdio_in_oe_d = 1'b0;
            mdio_in_d    = 1'b0;
            state_d      = S_IDLE;
          end else if (bit_cnt_q == CW'(16)) begin
            mdio_in_oe_d = 1'b0;
            mdio_in_d    = 1'b0;
            rd_done_d    = 1'b1;
            state_d      = S_IDLE;
          end
        end else if (fall_c && (bit_cnt_q < CW'(16))) begin
          mdio_in_d = rd_sh_q[DW-1];
          rd_sh_d   = {rd_sh_q[DW-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CW'(1);
        end
      end

      // Foreign-PHY frame: swallow TA plus 16 data rises without driving or erroring.
      S_SKIP: begin
        if (rise_c) begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          if (bit_cnt_q == CW'(17)) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) bit_cnt_d = '0;
  end

  assign mdio_in    = mdio_in_q;
  assign mdio_in_oe = mdio_in_oe_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign rd_done    = rd_done_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_mdio_receptor.sv
// Directed bench for mdio_receptor: table of write-type frames, each followed by a read-back,
// plus hand-written contention, PHYAD and mid-frame reset sequences.
module tb_mdio_receptor;

  logic        clk = 1'b0;
  logic        reset, mdc, mdio_out, mdio_oe;
  logic        mdio_in, mdio_in_oe, wr_en, rd_done, frame_err;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int n_pass = 0;
  int n_chk  = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int rd_cnt = 0;
  logic [4:0]  last_wa = '0;
  logic [15:0] last_wd = '0;

  always #5 clk = ~clk;

  mdio_receptor #(.PHY_ADDR(5'h01)) dut (
    .clk        (clk),
    .reset      (reset),
    .mdc        (mdc),
    .mdio_out   (mdio_out),
    .mdio_oe    (mdio_oe),
    .mdio_in    (mdio_in),
    .mdio_in_oe (mdio_in_oe),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_done    (rd_done),
    .frame_err  (frame_err)
  );

  // Pulse counters: one count per clk the pulse is high.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_cnt  = wr_cnt + 1;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
    if (frame_err) err_cnt = err_cnt + 1;
    if (rd_done)   rd_cnt  = rd_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish, got running, expected finished");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [1:0]  ta;
    logic [15:0] data;
    int          nbits;
    int          drop_at;
    int          exp_wr;
    int          exp_err;
    logic [15:0] exp_reg;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One mdc period (3 clk low, 3 clk high); returns the DUT drive seen at the rise.
  task automatic mdc_cycle(input logic oe, input logic b, output logic si, output logic so);
    @(negedge clk);
    mdio_oe  = oe;
    mdio_out = b;
    repeat (2) @(negedge clk);
    si  = mdio_in;
    so  = mdio_in_oe;
    mdc = 1'b1;
    repeat (3) @(negedge clk);
    mdc = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int nbits, input int drop_at,
                            input int npre);
    logic si, so;
    for (int i = 0; i < npre; i++) mdc_cycle(1'b1, 1'b1, si, so);
    for (int i = 0; i < nbits; i++) begin
      if (i == drop_at) begin
        mdc_cycle(1'b0, bits[31-i], si, so);
        break;
      end
      mdc_cycle(1'b1, bits[31-i], si, so);
    end
    mdio_oe = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] phy, input logic [4:0] ra, input logic [15:0] exp,
                         input int npre, input string name);
    logic [13:0] hdr;
    logic [16:0] got;
    logic        si, so, oe_all;
    int          r0, e0;
    hdr    = {2'b01, 2'b10, phy, ra};
    r0     = rd_cnt;
    e0     = err_cnt;
    oe_all = 1'b1;
    for (int i = 0; i < npre; i++) mdc_cycle(1'b1, 1'b1, si, so);
    for (int i = 13; i >= 0; i--) mdc_cycle(1'b1, hdr[i], si, so);
    for (int i = 0; i < 17; i++) begin
      mdc_cycle(1'b0, 1'b0, si, so);
      got[16-i] = si;
      oe_all    = oe_all & so;
    end
    idle(4);
    chk({name, "_data"}, 32'(got), 32'({1'b0, exp}));
    chk({name, "_oe"}, 32'(oe_all), 32'd1);
    chk({name, "_rd_done"}, rd_cnt - r0, 32'd1);
    chk({name, "_oe_off"}, 32'(mdio_in_oe), 32'd0);
    chk({name, "_no_err"}, err_cnt - e0, 32'd0);
  endtask

  initial begin
    int          w0, e0, r0;
    logic [31:0] bits;
    logic [13:0] hdr;
    logic        si, so;

    vecs[0] = '{2'b01, 2'b01, 5'd1, 5'd3,  2'b10, 16'hA5C3, 32, -1, 1, 0, 16'hA5C3};
    vecs[1] = '{2'b01, 2'b01, 5'd1, 5'd0,  2'b10, 16'hFFFF, 32, -1, 1, 0, 16'h0000};
    vecs[2] = '{2'b01, 2'b11, 5'd1, 5'd3,  2'b10, 16'h1234,  4, -1, 0, 1, 16'hA5C3};
    vecs[3] = '{2'b01, 2'b01, 5'd1, 5'd3,  2'b01, 16'h1111, 16, -1, 0, 1, 16'hA5C3};
    vecs[4] = '{2'b01, 2'b01, 5'd1, 5'd3,  2'b10, 16'h5555, 32, 24, 0, 1, 16'hA5C3};
    vecs[5] = '{2'b01, 2'b01, 5'd1, 5'd31, 2'b10, 16'h8001, 32, -1, 1, 0, 16'h8001};
    vecs[6] = '{2'b01, 2'b00, 5'd1, 5'd3,  2'b10, 16'h0000,  4, -1, 0, 1, 16'hA5C3};
    vecs[7] = '{2'b00, 2'b01, 5'd1, 5'd3,  2'b10, 16'h0000,  2, -1, 0, 1, 16'hA5C3};

    reset    = 1'b0;
    mdc      = 1'b0;
    mdio_out = 1'b1;
    mdio_oe  = 1'b0;
    idle(3);
    chk("reset_outs", 32'({mdio_in, mdio_in_oe, wr_en, rd_done, frame_err, wr_addr, wr_data}),
        32'd0);
    reset = 1'b1;
    idle(3);

    for (int i = 0; i < 8; i++) begin
      w0   = wr_cnt;
      e0   = err_cnt;
      bits = {vecs[i].st, vecs[i].op, vecs[i].phy, vecs[i].ra, vecs[i].ta, vecs[i].data};
      send_frame(bits, vecs[i].nbits, vecs[i].drop_at, 3);
      idle(4);
      chk($sformatf("vec%0d_wr_cnt", i), wr_cnt - w0, 32'(vecs[i].exp_wr));
      chk($sformatf("vec%0d_err_cnt", i), err_cnt - e0, 32'(vecs[i].exp_err));
      if (vecs[i].exp_wr != 0) begin
        chk($sformatf("vec%0d_wr_addr", i), 32'(last_wa), 32'(vecs[i].ra));
        chk($sformatf("vec%0d_wr_data", i), 32'(last_wd), 32'(vecs[i].data));
      end
      do_read(5'd1, vecs[i].ra, vecs[i].exp_reg, 2, $sformatf("vec%0d_rd", i));
    end

    // Generator drives during read data: abort with one error and release the line.
    e0  = err_cnt;
    r0  = rd_cnt;
    hdr = {2'b01, 2'b10, 5'd1, 5'd3};
    mdc_cycle(1'b1, 1'b1, si, so);
    for (int i = 13; i >= 0; i--) mdc_cycle(1'b1, hdr[i], si, so);
    mdc_cycle(1'b0, 1'b0, si, so);
    mdc_cycle(1'b0, 1'b0, si, so);
    mdc_cycle(1'b1, 1'b1, si, so);
    mdio_oe = 1'b0;
    idle(4);
    chk("contention_err", err_cnt - e0, 32'd1);
    chk("contention_oe_off", 32'(mdio_in_oe), 32'd0);
    chk("contention_no_done", rd_cnt - r0, 32'd0);
    do_read(5'd1, 5'd3, 16'hA5C3, 2, "post_contention_rd");

`ifdef MDIO_PHYADDR_CHECK_EN
    w0 = wr_cnt;
    e0 = err_cnt;
    send_frame({2'b01, 2'b01, 5'd2, 5'd3, 2'b10, 16'h0F0F}, 32, -1, 2);
    do_read(5'd1, 5'd3, 16'hA5C3, 0, "phy_next_rd");
    chk("phy_foreign_no_wr", wr_cnt - w0, 32'd0);
    chk("phy_foreign_no_err", err_cnt - e0, 32'd0);
`else
    w0 = wr_cnt;
    send_frame({2'b01, 2'b01, 5'd2, 5'd3, 2'b10, 16'h0F0F}, 32, -1, 2);
    idle(4);
    chk("phy_any_wr", wr_cnt - w0, 32'd1);
    chk("phy_any_wr_data", 32'(last_wd), 32'h0F0F);
    do_read(5'd2, 5'd3, 16'h0F0F, 2, "phy_any_rd");
`endif

    // Reset while WDATA bit 8 is due: everything clears, bank included.
    w0 = wr_cnt;
    e0 = err_cnt;
    send_frame({2'b01, 2'b01, 5'd1, 5'd3, 2'b10, 16'h7777}, 24, -1, 2);
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    chk("rst_mid_outs",
        32'({mdio_in, mdio_in_oe, wr_en, rd_done, frame_err, wr_addr, wr_data}), 32'd0);
    reset = 1'b1;
    idle(3);
    chk("rst_mid_no_wr", wr_cnt - w0, 32'd0);
    do_read(5'd1, 5'd3, 16'h0000, 2, "rst_bank_cleared_rd");
    send_frame({2'b01, 2'b01, 5'd1, 5'd5, 2'b10, 16'h0BEE}, 32, -1, 2);
    idle(4);
    chk("rst_after_wr_cnt", wr_cnt - w0, 32'd1);
    chk("rst_after_wr_addr", 32'(last_wa), 32'd5);
    chk("rst_after_wr_data", 32'(last_wd), 32'h0BEE);
    chk("rst_after_no_err", err_cnt - e0, 32'd0);
    do_read(5'd1, 5'd5, 16'h0BEE, 2, "rst_after_rd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
